ps2_frame_rx: RTL and testbench
===============================

Name: ps2_frame_rx

Overview:
PS/2 device-to-host receiver that sits directly upstream of the keyboard scancode state machine and feeds it raw scancode bytes. It synchronises ps2_clk and ps2_data into the system clock domain and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). Valid bytes are buffered in a small FIFO, which the consumer drains with an active-low pop strobe. Framing and parity errors are dropped, counted and flagged, never forwarded.

Parameters:
FIFO_DEPTH, 8, number of buffered bytes; power of two, minimum 2.
TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before the partial frame is discarded (about 1 ms at 50 MHz).
ERR_CNT_W, 8, width of the error counter.

Ports:
clk  in  1  system clock.
clr  in  1  reset: synchronous, active-high.
ps2_clk  in  1  raw PS/2 clock from the pad; asynchronous.
ps2_data  in  1  raw PS/2 data from the pad; asynchronous.
nextdata_n  in  1  active-low pop; one byte consumed per clk cycle it is low while ready=1.
data  out  8  FIFO head byte; valid while ready=1.
ready  out  1  FIFO not empty.
overflow  out  1  sticky; a valid frame arrived while the FIFO was full.
sampling  out  1  one-cycle pulse per detected ps2_clk falling edge.
frame_err  out  1  one-cycle pulse when a frame is rejected (bad start, parity, stop, or timeout).
err_count  out  ERR_CNT_W  count of rejected frames; saturates at all-ones.

Behaviour:
- Reset (clr=1 at a clk edge): FIFO emptied (rd_ptr=wr_ptr=0, count=0); data=0, ready=0, overflow=0, sampling=0, frame_err=0, err_count=0; bit counter=0; shift register=0; synchroniser flops=1 (bus idle). Reset takes effect mid-frame and discards the partial frame.
- Synchroniser: 3-flop chain on ps2_clk and a 2-flop chain on ps2_data. A falling edge is sync[2]=1 and sync[1]=0. sampling pulses for exactly 1 cycle, 3 clk cycles after the pad edge (+0/1 cycle of sync jitter). Data is sampled on that same cycle.
- Deframer states: IDLE, SHIFT, CHECK.
  - IDLE: on a sampling edge, if data=0 (start bit), go to SHIFT with bit_cnt=0. If data=1, stay in IDLE, with no error.
  - SHIFT: each sampling edge shifts data in, LSB first, for 8 data bits, then parity, then stop. After the stop bit go to CHECK.
  - CHECK (1 cycle): accept if (^byte ^ parity)=1 and stop=1; otherwise reject. Always return to IDLE.
- Timeout: in SHIFT, a free-running idle counter resets on every sampling pulse. When it reaches TIMEOUT_CYCLES, the frame is rejected and the state returns to IDLE.
- Reject: frame_err pulses 1 cycle; err_count increments and saturates; the FIFO is untouched.
- Accept, FIFO not full: byte written at the CHECK cycle. ready=1 and data valid on the next cycle. Latency from the stop-bit pad edge to ready is 5 cycles or fewer.
- Accept, FIFO full, no pop that cycle: byte dropped, overflow set (sticky until clr).
- Accept while full with pop in the same cycle: pop then push. Byte accepted, count unchanged, overflow not set.
- Pop while empty (nextdata_n=0, ready=0): ignored; pointers unchanged.
- Push and pop in the same cycle, not full or empty: count unchanged; data advances to the next entry on the following cycle.
- data is registered from the FIFO head (first-word-fall-through). After a pop, data shows the next byte one cycle later. When empty, data holds its last value and ready=0.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are tracked with a separate count register of width log2(FIFO_DEPTH)+1.

Decomposition:
- Shared package ps2_pkg: frame state encoding (IDLE/SHIFT/CHECK), PS2_FRAME_BITS=11, and the scancode constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0, also used by the downstream keyboard FSM.
- One sub-module: ps2_sync_fifo (parameterised depth and width; push, pop, full, empty, count, FWFT head). The deframer and synchroniser stay in the top.

Test Plan:
- Make code 0x1C (parity 0, stop 1) at a 20 kHz PS/2 clock, no pops -> ready rises 5 cycles or fewer after the stop edge; data=8'h1C; sampling pulses exactly 11 times; err_count=0.
- Sequence 0x1C, 0xF0 (parity 1), 0x1C, then pop 3 times with one nextdata_n low cycle each -> data reads 1C, F0, 1C in order; ready=0 after the third pop.
- 0x1C sent with parity=1 -> frame_err pulses once; err_count=1; ready stays 0. A following good 0x32 is accepted normally.
- 9 good frames (0x01..0x09), FIFO_DEPTH=8, no pops -> overflow=1 after the 9th; popping yields 01..08 only. Repeat with a pop aligned to the 9th CHECK cycle -> overflow=0 and 02..09 remain.
- Stop ps2_clk after 5 data bits for TIMEOUT_CYCLES+10 cycles -> frame_err pulses once, state IDLE; a following complete 0x29 frame is received intact.
- Assert clr for 1 cycle mid-frame with 3 bytes buffered -> next cycle ready=0, overflow=0, err_count=0; the next full frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: deframer state encoding, frame geometry and the
// scancode prefixes also used by the downstream keyboard FSM.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_t;

    localparam int PS2_FRAME_BITS   = 11;
    // Bits captured after the start bit: 8 data, parity, stop.
    localparam int PS2_PAYLOAD_BITS = PS2_FRAME_BITS - 1;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // payload[7:0] = data, payload[8] = parity, payload[9] = stop.
    function automatic logic frame_ok(input logic [PS2_PAYLOAD_BITS-1:0] payload);
        return (^payload[8:0]) && payload[9];
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head. A pop and
// push on a full FIFO in the same cycle are both honoured.
module ps2_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign empty       = (count == '0);
    assign full        = (count == FULL_CNT);
    assign do_pop      = pop & ~empty;
    assign do_push     = push & (~full | do_pop);
    assign rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The slot being written is never the next head unless the FIFO holds
    // exactly one entry (or none), so those cases bypass the incoming byte.
    always_comb begin
        head_next = head;
        if (do_pop) begin
            if (count != ONE_CNT) begin
                head_next = mem[rd_ptr_next];
            end else if (do_push) begin
                head_next = wr_data;
            end
        end else if (empty && do_push) begin
            head_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            head <= '0;
        end else begin
            head <= head_next;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: synchronises the pad signals, deframes
// 11-bit frames and buffers accepted bytes for the scancode FSM.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 nextdata_n,
    output logic [7:0]           data,
    output logic                 ready,
    output logic                 overflow,
    output logic                 sampling,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [3:0] LAST_BIT = 4'(PS2_PAYLOAD_BITS - 1);

    logic [2:0]                  clk_sync;
    logic [1:0]                  data_sync;
    logic                        fall_det;
    logic                        bit_in;

    frame_state_t                state;
    frame_state_t                state_next;
    logic [3:0]                  bit_cnt;
    logic [PS2_PAYLOAD_BITS-1:0] shift_reg;
    logic [IDLE_W-1:0]           idle_cnt;
    logic                        timeout;
    logic                        accept;
    logic                        reject;

    logic                        pop_req;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Flops preset to 1 so a reset never fabricates a falling edge on an idle bus.
    always_ff @(posedge clk) begin
        if (clr) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
            sampling  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            sampling  <= fall_det;
        end
    end

    assign fall_det = clk_sync[2] & ~clk_sync[1];
    assign bit_in   = data_sync[1];
    assign timeout  = (state == ST_SHIFT) && (idle_cnt == IDLE_LIMIT);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fall_det && !bit_in) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (timeout) begin
                    state_next = ST_IDLE;
                end else if (fall_det && (bit_cnt == LAST_BIT)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        accept = 1'b0;
        reject = timeout;
        if (state == ST_CHECK) begin
            accept = frame_ok(shift_reg);
            reject = ~frame_ok(shift_reg);
        end
    end

    // Bits arrive LSB first, so shifting right leaves data in [7:0],
    // parity in [8] and stop in [9] once the frame is complete.
    always_ff @(posedge clk) begin
        if (clr) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (fall_det) begin
                        shift_reg <= {bit_in, shift_reg[PS2_PAYLOAD_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        idle_cnt  <= '0;
                    end else begin
                        idle_cnt  <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end
            endcase
        end
    end

    assign pop_req = ~nextdata_n;
    assign ready   = (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            frame_err <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= reject;
            if (reject && !(&err_count)) begin
                err_count <= err_count + 1'b1;
            end
            if (accept && fifo_full && !(pop_req && !fifo_empty)) begin
                overflow <= 1'b1;
            end
        end
    end

    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .push    (accept),
        .pop     (pop_req),
        .wr_data (shift_reg[7:0]),
        .head    (data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: drives PS/2 frames on the pads and checks
// popped bytes against a queue of expected scancodes.
module tb_ps2_frame_rx;

    localparam int FIFO_DEPTH     = 8;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int ERR_CNT_W      = 8;
    localparam int HALF           = 20;

    logic                 clk;
    logic                 clr;
    logic                 ps2_clk;
    logic                 ps2_data;
    logic                 nextdata_n;
    logic [7:0]           data;
    logic                 ready;
    logic                 overflow;
    logic                 sampling;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;

    ps2_frame_rx #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ERR_CNT_W      (ERR_CNT_W)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .sampling   (sampling),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    int samp_cnt;
    int err_pulses;
    int ready_rise_cyc;
    bit ready_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (sampling === 1'b1) samp_cnt++;
        if (frame_err === 1'b1) err_pulses++;
        if (ready === 1'b1 && !ready_q) ready_rise_cyc = cyc;
        ready_q = (ready === 1'b1);
    end

    logic [7:0] exp_q[$];
    bit         exp_overflow;
    int         passed;
    int         total;
    int         stop_cyc;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        wait_cycles(1);
        clr = 1'b0;
        exp_q.delete();
        exp_overflow = 1'b0;
    endtask

    // Sends the first nbits of a frame; optionally pops during its CHECK cycle.
    task automatic apply_stimulus(input logic [7:0] b, input bit bad_parity,
                                  input int nbits, input bit pop_at_check);
        logic [10:0] frame;
        bit          found;
        frame = {1'b1, (~(^b)) ^ bad_parity, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            wait_cycles(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            if (i == 10 && pop_at_check) begin
                found = 1'b0;
                for (int k = 0; k < 12; k++) begin
                    @(posedge clk);
                    #1;
                    if (sampling === 1'b1) begin
                        found = 1'b1;
                        break;
                    end
                end
                check_output("stop_sampling_seen", 32'(found), 32'd1);
                if (found) begin
                    check_output("head_at_check_pop", 32'(data), 32'(exp_q[0]));
                    nextdata_n = 1'b0;
                    @(posedge clk);
                    #2;
                    nextdata_n = 1'b1;
                    void'(exp_q.pop_front());
                end
            end
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cycles(HALF);
        if (nbits == 11 && !bad_parity) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
            else exp_overflow = 1'b1;
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check_output({tag, "_ready"}, 32'(ready), 32'd1);
        check_output({tag, "_data"}, 32'(data), 32'(exp));
        nextdata_n = 1'b0;
        wait_cycles(1);
        nextdata_n = 1'b1;
    endtask

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int lat;
        passed       = 0;
        total        = 0;
        exp_overflow = 1'b0;
        clr          = 1'b1;
        ps2_clk      = 1'b1;
        ps2_data     = 1'b1;
        nextdata_n   = 1'b1;
        wait_cycles(3);
        clr = 1'b0;
        check_output("rst_ready", 32'(ready), 32'd0);
        check_output("rst_data", 32'(data), 32'd0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        check_output("rst_err_count", 32'(err_count), 32'd0);
        check_output("rst_frame_err", 32'(frame_err), 32'd0);
        check_output("rst_sampling", 32'(sampling), 32'd0);

        $display("[TB] single make code 0x1C");
        base = samp_cnt;
        apply_stimulus(8'h1C, 1'b0, 11, 1'b0);
        lat = ready_rise_cyc - stop_cyc;
        check_output("sampling_pulses", 32'(samp_cnt - base), 32'd11);
        check_output("ready_latency_le5", 32'(lat >= 1 && lat <= 5), 32'd1);
        check_output("first_ready", 32'(ready), 32'd1);
        check_output("first_data", 32'(data), 32'(exp_q[0]));
        check_output("first_err_count", 32'(err_count), 32'd0);

        $display("[TB] sequence 1C F0 1C then three pops");
        apply_stimulus(8'hF0, 1'b0, 11, 1'b0);
        apply_stimulus(8'h1C, 1'b0, 11, 1'b0);
        pop_check("seq_pop0");
        pop_check("seq_pop1");
        pop_check("seq_pop2");
        check_output("seq_empty", 32'(ready), 32'd0);
        check_output("seq_data_held", 32'(data), 32'h1C);
        nextdata_n = 1'b0;
        wait_cycles(2);
        nextdata_n = 1'b1;
        check_output("pop_empty_ignored", 32'(ready), 32'd0);

        $display("[TB] parity error then good 0x32");
        base = err_pulses;
        apply_stimulus(8'h1C, 1'b1, 11, 1'b0);
        check_output("parity_err_pulse", 32'(err_pulses - base), 32'd1);
        check_output("parity_err_count", 32'(err_count), 32'd1);
        check_output("parity_ready", 32'(ready), 32'd0);
        apply_stimulus(8'h32, 1'b0, 11, 1'b0);
        pop_check("after_parity");
        check_output("after_parity_empty", 32'(ready), 32'd0);

        $display("[TB] timeout after five data bits then 0x29");
        base = err_pulses;
        apply_stimulus(8'h5A, 1'b0, 6, 1'b0);
        wait_cycles(TIMEOUT_CYCLES + 10);
        check_output("timeout_err_pulse", 32'(err_pulses - base), 32'd1);
        check_output("timeout_err_count", 32'(err_count), 32'd2);
        check_output("timeout_ready", 32'(ready), 32'd0);
        apply_stimulus(8'h29, 1'b0, 11, 1'b0);
        pop_check("after_timeout");

        $display("[TB] nine frames into depth eight, no pops");
        for (int v = 1; v <= 9; v++) apply_stimulus(8'(v), 1'b0, 11, 1'b0);
        check_output("ovf_set", 32'(overflow), 32'(exp_overflow));
        for (int v = 1; v <= 8; v++) pop_check("ovf_pop");
        check_output("ovf_drained", 32'(ready), 32'd0);
        check_output("ovf_sticky", 32'(overflow), 32'd1);

        $display("[TB] reset mid-frame with three bytes buffered");
        apply_stimulus(8'h11, 1'b0, 11, 1'b0);
        apply_stimulus(8'h22, 1'b0, 11, 1'b0);
        apply_stimulus(8'h33, 1'b0, 11, 1'b0);
        apply_stimulus(8'hAA, 1'b0, 5, 1'b0);
        do_reset();
        check_output("clr_ready", 32'(ready), 32'd0);
        check_output("clr_overflow", 32'(overflow), 32'd0);
        check_output("clr_err_count", 32'(err_count), 32'd0);
        apply_stimulus(8'h4B, 1'b0, 11, 1'b0);
        pop_check("after_clr");
        check_output("after_clr_empty", 32'(ready), 32'd0);

        $display("[TB] full FIFO with pop aligned to the ninth CHECK");
        for (int v = 1; v <= 8; v++) apply_stimulus(8'(v), 1'b0, 11, 1'b0);
        apply_stimulus(8'h09, 1'b0, 11, 1'b1);
        check_output("aligned_no_overflow", 32'(overflow), 32'(exp_overflow));
        for (int v = 2; v <= 9; v++) pop_check("aligned_pop");
        check_output("aligned_drained", 32'(ready), 32'd0);
        check_output("final_err_count", 32'(err_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
